// File: rtl/vend_session_controller.sv
// Vending session controller: sequences buy, owner charge, owner withdraw and
// status requests through one shared stock/bank datapath.
module vend_session_controller #(
    parameter int unsigned NUM_ITEMS  = 4,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned MONEY_W    = 8,
    parameter int unsigned PRICE0     = 5,
    parameter int unsigned PRICE1     = 7,
    parameter int unsigned PRICE2     = 10,
    parameter int unsigned PRICE3     = 12,
    parameter logic [5:0]  OWNER_PASS = 6'b001101,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         usermode,
    input  logic [1:0]         stuffmode,
    input  logic [5:0]         ownerpass,
    input  logic [STOCK_W-1:0] addsize,
    input  logic [MONEY_W-1:0] withdrawmoney,
    input  logic               coin_valid,
    input  logic [3:0]         coin_value,
    input  logic               canclebutton,
    output logic               busy,
    output logic [MONEY_W-1:0] credit,
    output logic [MONEY_W-1:0] pmoney,
    output logic [STOCK_W-1:0] stock_level,
    output logic               product_valid,
    output logic [1:0]         product_id,
    output logic               change_valid,
    output logic [MONEY_W-1:0] change_amount,
    output logic               payout_valid,
    output logic [MONEY_W-1:0] payout_amount,
    output logic               coin_reject,
    output logic [3:0]         redlight
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        VEND,
        CHARGE,
        WITHDRAW,
        STATUS
    } state_t;

    state_t             state;
    logic [1:0]         item_q;
    logic [STOCK_W-1:0] addsize_q;
    logic [MONEY_W-1:0] wd_q;
    logic [TW-1:0]      timer;
    logic [STOCK_W-1:0] stock [NUM_ITEMS];
    logic [MONEY_W-1:0] price;
    logic [MONEY_W:0]   coin_sum;
    logic [MONEY_W:0]   bank_sum;
    logic [STOCK_W:0]   stock_sum;

    always_comb begin
        price = MONEY_W'(PRICE0);
        case (item_q)
            2'd0:    price = MONEY_W'(PRICE0);
            2'd1:    price = MONEY_W'(PRICE1);
            2'd2:    price = MONEY_W'(PRICE2);
            default: price = MONEY_W'(PRICE3);
        endcase
    end

    // One extra bit on each sum exposes the overflow that must be refused.
    assign coin_sum    = {1'b0, credit} + (MONEY_W+1)'(coin_value);
    assign bank_sum    = {1'b0, pmoney} + {1'b0, price};
    assign stock_sum   = {1'b0, stock[item_q]} + {1'b0, addsize_q};
    assign busy        = (state != IDLE);
    assign stock_level = stock[item_q];

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            item_q        <= '0;
            addsize_q     <= '0;
            wd_q          <= '0;
            timer         <= '0;
            credit        <= '0;
            pmoney        <= '0;
            product_valid <= 1'b0;
            product_id    <= '0;
            change_valid  <= 1'b0;
            change_amount <= '0;
            payout_valid  <= 1'b0;
            payout_amount <= '0;
            coin_reject   <= 1'b0;
            redlight      <= '0;
            for (int unsigned i = 0; i < NUM_ITEMS; i++) stock[i] <= '0;
        end else begin
            product_valid <= 1'b0;
            change_valid  <= 1'b0;
            payout_valid  <= 1'b0;
            coin_reject   <= 1'b0;
            change_amount <= '0;
            payout_amount <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        item_q    <= stuffmode;
                        addsize_q <= addsize;
                        wd_q      <= withdrawmoney;
                        redlight  <= '0;
                        credit    <= '0;
                        timer     <= '0;
                        case (usermode)
                            2'd0: begin
                                if (stock[stuffmode] == '0) redlight[0] <= 1'b1;
                                else                        state <= COLLECT;
                            end
                            2'd1: begin
                                if (ownerpass != OWNER_PASS) redlight[1] <= 1'b1;
                                else                         state <= CHARGE;
                            end
                            2'd2: begin
                                if (ownerpass != OWNER_PASS) redlight[2] <= 1'b1;
                                else                         state <= WITHDRAW;
                            end
                            default: state <= STATUS;
                        endcase
                    end
                end
                COLLECT: begin
                    if (canclebutton) begin
                        coin_reject   <= coin_valid;
                        change_valid  <= (credit != '0);
                        change_amount <= credit;
                        credit        <= '0;
                        state         <= IDLE;
                    end else if (coin_valid && !coin_sum[MONEY_W]) begin
                        credit <= coin_sum[MONEY_W-1:0];
                        timer  <= '0;
                        if (coin_sum[MONEY_W-1:0] >= price) state <= VEND;
                    end else begin
                        // A refused coin does not restart the idle timeout.
                        coin_reject <= coin_valid;
                        if (timer == TW'(TIMEOUT - 1)) begin
                            change_valid  <= (credit != '0);
                            change_amount <= credit;
                            credit        <= '0;
                            state         <= IDLE;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                VEND: begin
                    if (bank_sum[MONEY_W]) begin
                        redlight[0]   <= 1'b1;
                        change_valid  <= (credit != '0);
                        change_amount <= credit;
                    end else begin
                        product_valid  <= 1'b1;
                        product_id     <= item_q;
                        stock[item_q]  <= stock[item_q] - STOCK_W'(1);
                        pmoney         <= bank_sum[MONEY_W-1:0];
                        change_valid   <= (credit != price);
                        change_amount  <= credit - price;
                    end
                    credit <= '0;
                    state  <= IDLE;
                end
                CHARGE: begin
                    stock[item_q] <= stock_sum[STOCK_W] ? '1 : stock_sum[STOCK_W-1:0];
                    state         <= IDLE;
                end
                WITHDRAW: begin
                    if (wd_q <= pmoney) begin
                        pmoney        <= pmoney - wd_q;
                        payout_valid  <= 1'b1;
                        payout_amount <= wd_q;
                    end else begin
                        redlight[2] <= 1'b1;
                    end
                    state <= IDLE;
                end
                STATUS:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_session_controller.sv
// Self-checking bench for vend_session_controller: directed scenarios plus
// randomized transactions checked against a transaction-level model.
module tb_vend_session_controller;

    localparam logic [5:0]  PASS    = 6'b001101;
    localparam int unsigned TIMEOUT = 255;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [1:0] usermode = '0;
    logic [1:0] stuffmode = '0;
    logic [5:0] ownerpass = '0;
    logic [3:0] addsize = '0;
    logic [7:0] withdrawmoney = '0;
    logic       coin_valid = 1'b0;
    logic [3:0] coin_value = '0;
    logic       canclebutton = 1'b0;
    logic       busy;
    logic [7:0] credit;
    logic [7:0] pmoney;
    logic [3:0] stock_level;
    logic       product_valid;
    logic [1:0] product_id;
    logic       change_valid;
    logic [7:0] change_amount;
    logic       payout_valid;
    logic [7:0] payout_amount;
    logic       coin_reject;
    logic [3:0] redlight;

    vend_session_controller #(
        .PRICE3(255)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .usermode(usermode),
        .stuffmode(stuffmode), .ownerpass(ownerpass), .addsize(addsize),
        .withdrawmoney(withdrawmoney), .coin_valid(coin_valid),
        .coin_value(coin_value), .canclebutton(canclebutton), .busy(busy),
        .credit(credit), .pmoney(pmoney), .stock_level(stock_level),
        .product_valid(product_valid), .product_id(product_id),
        .change_valid(change_valid), .change_amount(change_amount),
        .payout_valid(payout_valid), .payout_amount(payout_amount),
        .coin_reject(coin_reject), .redlight(redlight)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int m_stock [4];
    int m_bank;
    int coinq [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int price_of(input int i);
        case (i)
            0:       return 5;
            1:       return 7;
            2:       return 10;
            default: return 255;
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        m_bank = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 0;
    endtask

    task automatic charge(input int item, input int add, input logic [5:0] pw);
        usermode = 2'd1; stuffmode = 2'(item); ownerpass = pw; addsize = 4'(add);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (pw == PASS) begin
            chk("chg_busy", busy, 1);
            chk("chg_red", redlight, 0);
            tick();
            m_stock[item] = (m_stock[item] + add > 15) ? 15 : m_stock[item] + add;
        end else begin
            chk("chg_red_auth", redlight, 4'b0010);
        end
        chk("chg_idle", busy, 0);
        chk("chg_stock", stock_level, m_stock[item]);
    endtask

    task automatic withdraw(input int amt, input logic [5:0] pw);
        usermode = 2'd2; ownerpass = pw; withdrawmoney = 8'(amt);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (pw == PASS) begin
            chk("wd_busy", busy, 1);
            tick();
            if (amt <= m_bank) begin
                chk("wd_payout_v", payout_valid, 1);
                chk("wd_payout_amt", payout_amount, amt);
                chk("wd_red", redlight, 0);
                m_bank -= amt;
            end else begin
                chk("wd_payout_v", payout_valid, 0);
                chk("wd_red_over", redlight, 4'b0100);
            end
        end else begin
            chk("wd_red_auth", redlight, 4'b0100);
            chk("wd_payout_v", payout_valid, 0);
        end
        chk("wd_idle", busy, 0);
        chk("wd_bank", pmoney, m_bank);
    endtask

    task automatic status(input int item);
        usermode = 2'd3; stuffmode = 2'(item);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("st_busy", busy, 1);
        chk("st_stock", stock_level, m_stock[item]);
        tick();
        chk("st_idle", busy, 0);
    endtask

    // ending: 0 cancel, 1 cancel with a coin in the same cycle, 2 timeout
    task automatic buy(input int item, input int ending);
        int cr;
        int idle;
        int p;
        bit vended;
        cr = 0; idle = 0; vended = 0;
        p = price_of(item);
        usermode = 2'd0; stuffmode = 2'(item);
        start = 1'b1;
        tick();
        start = 1'b0;
        if (m_stock[item] == 0) begin
            chk("buy_empty_red", redlight, 4'b0001);
            chk("buy_empty_busy", busy, 0);
            return;
        end
        chk("buy_busy", busy, 1);
        chk("buy_red", redlight, 0);
        for (int k = 0; k < coinq.size() && !vended; k++) begin
            coin_valid = 1'b1; coin_value = 4'(coinq[k]);
            tick();
            coin_valid = 1'b0;
            if (cr + coinq[k] > 255) begin
                chk("coin_reject", coin_reject, 1);
                idle++;
            end else begin
                chk("coin_reject", coin_reject, 0);
                cr += coinq[k];
                idle = 0;
            end
            chk("coin_credit", credit, cr);
            chk("coin_no_vend", product_valid, 0);
            if (cr >= p) vended = 1;
        end
        if (vended) begin
            chk("vend_busy", busy, 1);
            tick();
            if (m_bank + p > 255) begin
                chk("vend_ovf_red", redlight, 4'b0001);
                chk("vend_ovf_pv", product_valid, 0);
                chk("vend_ovf_cv", change_valid, 1);
                chk("vend_ovf_amt", change_amount, cr);
            end else begin
                chk("vend_pv", product_valid, 1);
                chk("vend_id", product_id, item);
                chk("vend_cv", change_valid, (cr != p));
                if (cr != p) chk("vend_change", change_amount, cr - p);
                m_stock[item]--;
                m_bank += p;
            end
        end else if (ending == 2) begin
            while (idle < TIMEOUT) begin
                if (idle == 10) begin
                    usermode = 2'd1; ownerpass = PASS; addsize = 4'd5; start = 1'b1;
                end
                tick();
                start = 1'b0;
                idle++;
                if (idle < TIMEOUT) chk("to_busy", busy, 1);
            end
            chk("to_cv", change_valid, (cr != 0));
            if (cr != 0) chk("to_amt", change_amount, cr);
        end else begin
            canclebutton = 1'b1;
            coin_valid = (ending == 1); coin_value = 4'd1;
            tick();
            canclebutton = 1'b0; coin_valid = 1'b0;
            chk("cancel_reject", coin_reject, (ending == 1));
            chk("cancel_cv", change_valid, (cr != 0));
            if (cr != 0) chk("cancel_amt", change_amount, cr);
        end
        chk("buy_idle", busy, 0);
        chk("buy_credit0", credit, 0);
        chk("buy_bank", pmoney, m_bank);
        chk("buy_stock", stock_level, m_stock[item]);
    endtask

    initial begin
        int r;
        int it;
        int amt;
        logic [5:0] pw;

        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_credit", credit, 0);
        chk("rst_bank", pmoney, 0);
        chk("rst_stock", stock_level, 0);
        chk("rst_red", redlight, 0);
        chk("rst_pv", product_valid, 0);

        charge(0, 3, PASS);
        coinq = '{2, 2, 2};
        buy(0, 0);
        charge(0, 5, 6'b000000);
        buy(1, 0);
        coinq = '{3};
        buy(0, 0);
        buy(0, 2);
        charge(1, 2, PASS);
        coinq = '{7};
        buy(1, 0);
        withdraw(13, PASS);
        withdraw(12, PASS);
        charge(2, 15, PASS);
        charge(2, 15, PASS);
        status(2);

        charge(3, 1, PASS);
        coinq = {};
        for (int i = 0; i < 16; i++) coinq.push_back(15);
        coinq.push_back(10);
        coinq.push_back(8);
        coinq.push_back(5);
        buy(3, 0);
        coinq = '{5};
        buy(0, 0);
        withdraw(255, PASS);

        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 9);
            it = $urandom_range(0, 3);
            pw = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : PASS;
            if (r <= 1) begin
                charge(it, $urandom_range(0, 15), pw);
            end else if (r == 2) begin
                amt = ($urandom_range(0, 1) == 0) ? $urandom_range(0, m_bank) : $urandom_range(0, 255);
                withdraw(amt, pw);
            end else if (r == 3) begin
                status(it);
            end else begin
                if (it == 3) it = $urandom_range(0, 2);
                coinq = {};
                for (int k = 0; k < $urandom_range(0, 4); k++) coinq.push_back($urandom_range(1, 15));
                buy(it, ($urandom_range(0, 7) == 0) ? 2 : $urandom_range(0, 1));
            end
        end

        charge(0, 4, PASS);
        usermode = 2'd0; stuffmode = 2'd0; start = 1'b1;
        tick();
        start = 1'b0;
        coin_valid = 1'b1; coin_value = 4'd3;
        tick();
        coin_valid = 1'b0;
        chk("mid_credit", credit, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_bank = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 0;
        chk("mid_rst_cv", change_valid, 0);
        chk("mid_rst_credit", credit, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_bank", pmoney, m_bank);
        chk("mid_rst_stock", stock_level, m_stock[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vend_session_controller.md
# vend_session_controller

Session controller that sequences all vending-machine transactions through a single shared stock/money datapath. It accepts one request at a time from the keypad decode and walks it through buy, owner charge or owner withdraw, with passcode checking, coin collection, timeout and cancel. Its credit, bank, stock, product and red-light outputs drive the product/seven-segment display logic.

## Interface
- NUM_ITEMS, 4, number of product slots (item index is 2 bits)
- STOCK_W, 4, stock counter width per slot
- MONEY_W, 8, credit, bank and amount width
- PRICE0..PRICE3, 5/7/10/12, per-slot price
- OWNER_PASS, 6'b001101, owner passcode
- TIMEOUT, 255, idle cycles allowed in coin collection

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  one-cycle request strobe, sampled only in IDLE
- usermode  in  2  0 buy, 1 charge supply, 2 withdraw money, 3 status
- stuffmode  in  2  item index
- ownerpass  in  6  passcode, sampled with start
- addsize  in  STOCK_W  units to add (charge)
- withdrawmoney  in  MONEY_W  amount to withdraw
- coin_valid  in  1  one-cycle coin strobe
- coin_value  in  4  coin value
- canclebutton  in  1  cancel current buy session
- busy  out  1  high whenever state is not IDLE
- credit  out  MONEY_W  coins inserted this session
- pmoney  out  MONEY_W  bank total
- stock_level  out  STOCK_W  stock of latched item
- product_valid  out  1  one-cycle vend pulse
- product_id  out  2  item vended, valid with product_valid
- change_valid  out  1  one-cycle refund/change pulse
- change_amount  out  MONEY_W  valid with change_valid
- payout_valid  out  1  one-cycle withdraw pulse
- payout_amount  out  MONEY_W  valid with payout_valid
- coin_reject  out  1  one-cycle pulse, coin refused
- redlight  out  4  error flags [0] buy, [1] charge auth, [2] withdraw, [3] reserved 0

## Operation
- States: IDLE, COLLECT, VEND, CHARGE, WITHDRAW, STATUS.
- IDLE + start: latch usermode, stuffmode, ownerpass, addsize, withdrawmoney; clear redlight. Mode 0: stock==0 → redlight[0], stay IDLE; else COLLECT. Mode 1/2: pass mismatch → redlight[1]/[2], stay IDLE; else CHARGE/WITHDRAW. Mode 3 → STATUS.
- COLLECT: coin_valid adds coin_value to credit; if sum exceeds 2^MONEY_W-1, coin refused (coin_reject, credit unchanged). credit ≥ price → VEND. canclebutton, or TIMEOUT cycles with no coin, → refund: change_valid with credit (only if credit≠0), credit cleared, IDLE. Cancel and coin in same cycle: cancel wins, coin rejected.
- VEND: if pmoney+price overflows → redlight[0], full refund; else product_valid, stock−1, pmoney+=price, change_valid with credit−price if nonzero; credit cleared; IDLE.
- CHARGE: stock[item] += addsize, saturating at 2^STOCK_W-1; IDLE.
- WITHDRAW: withdrawmoney ≤ pmoney → pmoney−=amount, payout_valid; else redlight[2], pmoney unchanged; IDLE.
- STATUS: one cycle, stock_level reflects item; IDLE.
- redlight bits hold until next accepted start or reset.

## Timing
- Reset: state IDLE, all stock 0, credit 0, pmoney 0, all pulses 0, redlight 0, busy 0.
- start accepted at edge N → new state/redlight visible after edge N; start while busy ignored.
- Coin at edge N reaching price → VEND after N, product_valid after N+1.
- Timeout counter resets on entry to COLLECT and on each accepted coin; expiry on TIMEOUT-th idle cycle.
- CHARGE/WITHDRAW/STATUS complete one cycle after entry; busy falls the same edge.
- reset mid-session: credit discarded, no change pulse.

## Test plan
- Reset, mode1 pass OK, item0 addsize 3; mode0 item0, coins 2,2,2 → product_valid id0, change 1, pmoney 5, stock 2.
- Mode1 with pass 6'b000000 → redlight[1]=1, stock unchanged, busy stays 0.
- Buy item1 at stock 0 → redlight[0], no COLLECT; stock 2, insert 3 then cancel → change_valid 3, credit 0.
- Insert 3, wait TIMEOUT cycles → refund 3, IDLE; start during COLLECT ignored.
- pmoney 12, withdraw 13 → redlight[2], pmoney 12; withdraw 12 → payout 12, pmoney 0.
- Charge addsize 15 twice → stock saturates 15; credit at 250 plus coin 8 → coin_reject, credit 250.
